// File: rtl/eeprom_page_write_sched.sv
// -----------------------------------------------------------------------------
// eeprom_page_write_sched
//
// Sequences EEPROM page writes. Bytes are drained from a first-word-fall-through
// write FIFO and issued to the I2C byte engine as page-aligned bursts:
// START+word address, data bytes, STOP. A tWR write-cycle gap is enforced after
// every STOP before the next burst (or completion) is allowed.
//
// Ports
//   sys_clk, sys_rst            clock (rising edge), asynchronous active-high reset
//   start, start_addr, byte_cnt request pulse plus its address/length (IDLE only)
//   abort                       cancels an active transfer
//   fifo_empty, fifo_dout       FWFT FIFO status and head byte
//   fifo_rd_en, fifo_reset      FIFO pop strobe and flush pulse
//   i2c_cmd_valid/ready         command handshake towards the I2C engine
//   i2c_cmd_op/addr/data        command payload (0=START, 1=WRITE, 2=STOP)
//   i2c_nack                    slave NACK pulse from the I2C engine
//   busy, done, err             status: active, success pulse, failure pulse
// -----------------------------------------------------------------------------
module eeprom_page_write_sched #(
  parameter int ADDR_W     = 16,
  parameter int PAGE_SIZE  = 32,
  parameter int CNT_W      = 16,
  parameter int TWR_CYCLES = 250000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  byte_cnt,
  input  logic              abort,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_dout,
  output logic              fifo_rd_en,
  output logic              fifo_reset,
  output logic              i2c_cmd_valid,
  input  logic              i2c_cmd_ready,
  output logic [1:0]        i2c_cmd_op,
  output logic [ADDR_W-1:0] i2c_cmd_addr,
  output logic [7:0]        i2c_cmd_data,
  input  logic              i2c_nack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Counter only has to hold TWR_CYCLES-1; keep at least one bit.
  localparam int TWR_W = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;
  localparam logic [TWR_W-1:0]  TWR_LOAD  = TWR_W'(TWR_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_STOP,
    ST_TWR,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]  rem_reg, rem_next;
  logic [TWR_W-1:0]  twr_cnt_reg, twr_cnt_next;
  logic              zero_err_reg, zero_err_next;

  logic [ADDR_W-1:0] addr_inc;
  logic              data_hs;

  // Natural modulo-2^ADDR_W wrap; address 0 is also a page boundary.
  assign addr_inc = addr_reg + ADDR_W'(1);
  assign data_hs  = !fifo_empty && i2c_cmd_ready;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      rem_reg      <= '0;
      twr_cnt_reg  <= '0;
      zero_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      rem_reg      <= rem_next;
      twr_cnt_reg  <= twr_cnt_next;
      zero_err_reg <= zero_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    rem_next      = rem_reg;
    twr_cnt_next  = twr_cnt_reg;
    zero_err_next = 1'b0;

    fifo_rd_en    = 1'b0;
    fifo_reset    = 1'b0;
    i2c_cmd_valid = 1'b0;
    i2c_cmd_op    = OP_START;
    i2c_cmd_addr  = addr_reg;
    i2c_cmd_data  = 8'h00;
    busy          = (state_reg != ST_IDLE);
    done          = 1'b0;
    // A zero-length request is rejected from IDLE without touching the FIFO.
    err           = zero_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (byte_cnt != '0) begin
            addr_next  = start_addr;
            rem_next   = byte_cnt;
            state_next = ST_ADDR;
          end else begin
            zero_err_next = 1'b1;
          end
        end
      end

      ST_ADDR: begin
        i2c_cmd_valid = 1'b1;
        i2c_cmd_op    = OP_START;
        if (abort || i2c_nack) begin
          state_next = ST_ERR;
        end else if (i2c_cmd_ready) begin
          state_next = ST_DATA;
        end
      end

      ST_DATA: begin
        // Empty FIFO simply stalls the burst with valid low; no timeout.
        i2c_cmd_valid = !fifo_empty;
        i2c_cmd_op    = OP_WRITE;
        i2c_cmd_data  = fifo_dout;
        // A byte accepted by the engine is popped even if abort wins this cycle.
        if (data_hs) begin
          fifo_rd_en = 1'b1;
          addr_next  = addr_inc;
          rem_next   = rem_reg - CNT_W'(1);
        end
        if (abort || i2c_nack) begin
          state_next = ST_ERR;
        end else if (data_hs &&
                     ((rem_reg == CNT_W'(1)) || ((addr_inc & PAGE_MASK) == '0))) begin
          state_next = ST_STOP;
        end
      end

      ST_STOP: begin
        i2c_cmd_valid = 1'b1;
        i2c_cmd_op    = OP_STOP;
        if (abort || i2c_nack) begin
          state_next = ST_ERR;
        end else if (i2c_cmd_ready) begin
          twr_cnt_next = TWR_LOAD;
          state_next   = ST_TWR;
        end
      end

      ST_TWR: begin
        // The EEPROM is busy programming; NACKs here are expected and ignored.
        if (abort) begin
          state_next = ST_ERR;
        end else if (twr_cnt_reg == '0) begin
          state_next = (rem_reg == '0) ? ST_DONE : ST_ADDR;
        end else begin
          twr_cnt_next = twr_cnt_reg - TWR_W'(1);
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      ST_ERR: begin
        fifo_reset = 1'b1;
        err        = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_eeprom_page_write_sched.sv
// -----------------------------------------------------------------------------
// tb_eeprom_page_write_sched
//
// Directed bench for eeprom_page_write_sched. Expected I2C commands are pushed
// to a scoreboard queue as each request is set up and popped whenever the DUT
// completes a command handshake. A small FWFT FIFO model feeds the data port.
// -----------------------------------------------------------------------------
module tb_eeprom_page_write_sched;

  localparam int ADDR_W    = 16;
  localparam int PAGE_SIZE = 32;
  localparam int CNT_W     = 16;
  localparam int TWR       = 6;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  byte_cnt;
  logic              abort;
  logic              fifo_empty = 1'b1;
  logic [7:0]        fifo_dout  = 8'h00;
  logic              fifo_rd_en;
  logic              fifo_reset;
  logic              i2c_cmd_valid;
  logic              i2c_cmd_ready;
  logic [1:0]        i2c_cmd_op;
  logic [ADDR_W-1:0] i2c_cmd_addr;
  logic [7:0]        i2c_cmd_data;
  logic              i2c_nack;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  exp_t       mon_e;

  int n_total   = 0;
  int n_pass    = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int last_stop = -1;
  int n_hs      = 0;
  int n_done    = 0;
  int n_err     = 0;
  int n_frst    = 0;
  int n_pop     = 0;

  eeprom_page_write_sched #(
    .ADDR_W    (ADDR_W),
    .PAGE_SIZE (PAGE_SIZE),
    .CNT_W     (CNT_W),
    .TWR_CYCLES(TWR)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .start_addr   (start_addr),
    .byte_cnt     (byte_cnt),
    .abort        (abort),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_reset   (fifo_reset),
    .i2c_cmd_valid(i2c_cmd_valid),
    .i2c_cmd_ready(i2c_cmd_ready),
    .i2c_cmd_op   (i2c_cmd_op),
    .i2c_cmd_addr (i2c_cmd_addr),
    .i2c_cmd_data (i2c_cmd_data),
    .i2c_nack     (i2c_nack),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_total++;
    assert (obs === req) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, req);
    end
  endtask

  task automatic exp_cmd(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
    exp_t t;
    t.op   = op;
    t.addr = a;
    t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic do_start(input logic [15:0] a, input logic [15:0] n);
    @(posedge sys_clk); #1;
    start      = 1'b1;
    start_addr = a;
    byte_cnt   = n;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int  d0   = n_done;
    int  e0   = n_err;
    bit  seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge sys_clk); #1;
      seen = (n_done != d0) || (n_err != e0);
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_hs(input int target, input string tag);
    for (int k = 0; k < 100 && n_hs < target; k++) begin
      @(posedge sys_clk); #1;
    end
    chk(tag, 32'(n_hs >= target), 32'd1);
  endtask

  // FWFT FIFO model: pop/flush on the clock edge, present the new head a little later.
  always @(posedge sys_clk) begin
    cyc++;
    if (fifo_reset) begin
      fifo_q.delete();
    end else if (fifo_rd_en) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      n_pop++;
    end
    #2;
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  end

  // Command monitor and scoreboard, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (i2c_cmd_valid && i2c_cmd_ready) begin
        n_hs++;
        chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("cmd_op", 32'(i2c_cmd_op), 32'(mon_e.op));
          if (mon_e.op == 2'd0) chk("cmd_addr", 32'(i2c_cmd_addr), 32'(mon_e.addr));
          if (mon_e.op == 2'd1) chk("cmd_data", 32'(i2c_cmd_data), 32'(mon_e.data));
        end
        if (i2c_cmd_op == 2'd0 && last_stop >= 0) chk("twr_gap", 32'(cyc - last_stop), 32'(TWR + 1));
        if (i2c_cmd_op == 2'd2) last_stop = cyc;
      end
      if (done) begin
        n_done++;
        chk("done_latency", 32'(cyc - last_stop), 32'(TWR + 1));
        last_stop = -1;
      end
      if (err) begin
        n_err++;
        last_stop = -1;
      end
      if (fifo_reset) n_frst++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_done, b_err, b_pop, b_frst, b_hs;
    start         = 1'b0;
    start_addr    = '0;
    byte_cnt      = '0;
    abort         = 1'b0;
    i2c_cmd_ready = 1'b1;
    i2c_nack      = 1'b0;
    sys_rst       = 1'b0;
    #2 sys_rst = 1'b1;

    // Reset state
    @(negedge sys_clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(i2c_cmd_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_fifo_reset", 32'(fifo_reset), 32'd0);
    chk("rst_addr", 32'(i2c_cmd_addr), 32'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // 1: single page, 4 bytes from 0x0000
    b_done = n_done; b_err = n_err; b_pop = n_pop;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    exp_cmd(2'd0, 16'h0000, 8'h00);
    exp_cmd(2'd1, 16'h0000, 8'h11);
    exp_cmd(2'd1, 16'h0000, 8'h22);
    exp_cmd(2'd1, 16'h0000, 8'h33);
    exp_cmd(2'd1, 16'h0000, 8'h44);
    exp_cmd(2'd2, 16'h0000, 8'h00);
    do_start(16'h0000, 16'd4);
    @(negedge sys_clk);
    chk("t1_start_latency_valid", 32'(i2c_cmd_valid), 32'd1);
    chk("t1_start_latency_op", 32'(i2c_cmd_op), 32'd0);
    wait_end("t1_finish");
    chk("t1_done_count", 32'(n_done - b_done), 32'd1);
    chk("t1_err_count", 32'(n_err - b_err), 32'd0);
    chk("t1_pops", 32'(n_pop - b_pop), 32'd4);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: partial first page at 0x001E, crosses into 0x0020
    b_done = n_done; b_pop = n_pop;
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4); push_byte(8'hA5);
    exp_cmd(2'd0, 16'h001E, 8'h00);
    exp_cmd(2'd1, 16'h0000, 8'hA1);
    exp_cmd(2'd1, 16'h0000, 8'hA2);
    exp_cmd(2'd2, 16'h0000, 8'h00);
    exp_cmd(2'd0, 16'h0020, 8'h00);
    exp_cmd(2'd1, 16'h0000, 8'hA3);
    exp_cmd(2'd1, 16'h0000, 8'hA4);
    exp_cmd(2'd1, 16'h0000, 8'hA5);
    exp_cmd(2'd2, 16'h0000, 8'h00);
    do_start(16'h001E, 16'd5);
    wait_end("t2_finish");
    chk("t2_done_count", 32'(n_done - b_done), 32'd1);
    chk("t2_pops", 32'(n_pop - b_pop), 32'd5);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: address wrap 0xFFFF -> 0x0000
    b_done = n_done; b_pop = n_pop;
    push_byte(8'hB1); push_byte(8'hB2);
    exp_cmd(2'd0, 16'hFFFF, 8'h00);
    exp_cmd(2'd1, 16'h0000, 8'hB1);
    exp_cmd(2'd2, 16'h0000, 8'h00);
    exp_cmd(2'd0, 16'h0000, 8'h00);
    exp_cmd(2'd1, 16'h0000, 8'hB2);
    exp_cmd(2'd2, 16'h0000, 8'h00);
    do_start(16'hFFFF, 16'd2);
    wait_end("t3_finish");
    chk("t3_done_count", 32'(n_done - b_done), 32'd1);
    chk("t3_pops", 32'(n_pop - b_pop), 32'd2);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: FIFO runs dry mid-burst for 10 cycles
    b_done = n_done; b_pop = n_pop;
    push_byte(8'hC1); push_byte(8'hC2);
    exp_cmd(2'd0, 16'h0100, 8'h00);
    exp_cmd(2'd1, 16'h0000, 8'hC1);
    exp_cmd(2'd1, 16'h0000, 8'hC2);
    exp_cmd(2'd1, 16'h0000, 8'hC3);
    exp_cmd(2'd1, 16'h0000, 8'hC4);
    exp_cmd(2'd2, 16'h0000, 8'h00);
    do_start(16'h0100, 16'd4);
    for (int k = 0; k < 50 && n_pop < b_pop + 2; k++) begin
      @(posedge sys_clk); #1;
    end
    chk("t4_first_pops", 32'(n_pop - b_pop), 32'd2);
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      chk("t4_stall_valid", 32'(i2c_cmd_valid), 32'd0);
      chk("t4_stall_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("t4_stall_busy", 32'(busy), 32'd1);
    end
    @(posedge sys_clk); #1;
    push_byte(8'hC3); push_byte(8'hC4);
    wait_end("t4_finish");
    chk("t4_done_count", 32'(n_done - b_done), 32'd1);
    chk("t4_pops", 32'(n_pop - b_pop), 32'd4);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: NACK after the second data byte
    b_done = n_done; b_err = n_err; b_pop = n_pop; b_frst = n_frst; b_hs = n_hs;
    push_byte(8'hD1); push_byte(8'hD2); push_byte(8'hD3); push_byte(8'hD4);
    exp_cmd(2'd0, 16'h0040, 8'h00);
    exp_cmd(2'd1, 16'h0000, 8'hD1);
    exp_cmd(2'd1, 16'h0000, 8'hD2);
    do_start(16'h0040, 16'd4);
    wait_hs(b_hs + 3, "t5_reach_byte2");
    i2c_cmd_ready = 1'b0;
    i2c_nack      = 1'b1;
    @(posedge sys_clk); #1;
    i2c_nack      = 1'b0;
    i2c_cmd_ready = 1'b1;
    @(negedge sys_clk);
    chk("t5_err_pulse", 32'(err), 32'd1);
    chk("t5_fifo_reset", 32'(fifo_reset), 32'd1);
    chk("t5_valid_low", 32'(i2c_cmd_valid), 32'd0);
    @(negedge sys_clk);
    chk("t5_busy_low", 32'(busy), 32'd0);
    chk("t5_err_single", 32'(err), 32'd0);
    repeat (TWR + 4) begin
      @(posedge sys_clk); #1;
    end
    chk("t5_no_done", 32'(n_done - b_done), 32'd0);
    chk("t5_err_count", 32'(n_err - b_err), 32'd1);
    chk("t5_flush_count", 32'(n_frst - b_frst), 32'd1);
    chk("t5_pops", 32'(n_pop - b_pop), 32'd2);
    chk("t5_fifo_flushed", 32'(fifo_q.size()), 32'd0);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6a: zero-length request is rejected
    b_err = n_err; b_frst = n_frst; b_hs = n_hs;
    do_start(16'h0010, 16'd0);
    @(negedge sys_clk);
    chk("t6a_err_pulse", 32'(err), 32'd1);
    chk("t6a_busy", 32'(busy), 32'd0);
    chk("t6a_valid", 32'(i2c_cmd_valid), 32'd0);
    @(negedge sys_clk);
    chk("t6a_err_single", 32'(err), 32'd0);
    @(posedge sys_clk); #1;
    chk("t6a_err_count", 32'(n_err - b_err), 32'd1);
    chk("t6a_no_flush", 32'(n_frst - b_frst), 32'd0);
    chk("t6a_no_cmds", 32'(n_hs - b_hs), 32'd0);

    // 6b: held-off START stays stable, then abort during tWR
    b_done = n_done; b_err = n_err; b_frst = n_frst; b_hs = n_hs;
    i2c_cmd_ready = 1'b0;
    push_byte(8'hE1);
    exp_cmd(2'd0, 16'h0200, 8'h00);
    exp_cmd(2'd1, 16'h0000, 8'hE1);
    exp_cmd(2'd2, 16'h0000, 8'h00);
    do_start(16'h0200, 16'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      chk("t6b_hold_valid", 32'(i2c_cmd_valid), 32'd1);
      chk("t6b_hold_op", 32'(i2c_cmd_op), 32'd0);
      chk("t6b_hold_addr", 32'(i2c_cmd_addr), 32'h0200);
    end
    @(posedge sys_clk); #1;
    i2c_cmd_ready = 1'b1;
    wait_hs(b_hs + 3, "t6b_reach_twr");
    chk("t6b_twr_busy", 32'(busy), 32'd1);
    chk("t6b_twr_valid", 32'(i2c_cmd_valid), 32'd0);
    abort = 1'b1;
    @(posedge sys_clk); #1;
    abort = 1'b0;
    @(negedge sys_clk);
    chk("t6b_err_pulse", 32'(err), 32'd1);
    chk("t6b_fifo_reset", 32'(fifo_reset), 32'd1);
    @(negedge sys_clk);
    chk("t6b_busy_low", 32'(busy), 32'd0);
    repeat (TWR + 4) begin
      @(posedge sys_clk); #1;
    end
    chk("t6b_no_done", 32'(n_done - b_done), 32'd0);
    chk("t6b_err_count", 32'(n_err - b_err), 32'd1);
    chk("t6b_flush_count", 32'(n_frst - b_frst), 32'd1);
    chk("t6b_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
